// File: rtl/bp_pht_sched.sv
`default_nettype none
// ============================================================================
// bp_pht_sched : single-port PHT scheduler (init sweep, read/update arbitration, update FIFO)
// Revision     : 1.0
// ============================================================================
module bp_pht_sched #(
  parameter int unsigned PHT_DEPTH = 7,
  parameter int unsigned QDEPTH    = 4,
  parameter logic [1:0]  INIT_VAL  = 2'b01
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_req,
  input  logic                      rd_req,
  input  logic [PHT_DEPTH-1:0]      rd_index,
  input  logic                      upd_valid,
  input  logic [PHT_DEPTH-1:0]      upd_index,
  input  logic                      upd_taken,
  input  logic [1:0]                upd_ctr,
  output logic                      pht_en,
  output logic                      pht_we,
  output logic [PHT_DEPTH-1:0]      pht_addr,
  output logic [1:0]                pht_wdata,
  input  logic [1:0]                pht_rdata,
  output logic                      rd_grant,
  output logic                      pred_taken,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   qcount
);

  localparam int unsigned QW = $clog2(QDEPTH);
  localparam int unsigned EW = PHT_DEPTH + 3;
  localparam logic [QW:0]          C_QFULL   = (QW+1)'(QDEPTH);
  localparam logic [QW:0]          C_CNT_ONE = (QW+1)'(1);
  localparam logic [QW-1:0]        C_PTR_ONE = QW'(1);
  localparam logic [PHT_DEPTH-1:0] C_SWP_ONE = PHT_DEPTH'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PHT_DEPTH-1:0] sweep_q, sweep_d;
  logic [QW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [QW:0]          count_q, count_d;
  logic [EW-1:0]        fifo_q [QDEPTH];

  logic                 push;
  logic                 pop;
  logic [EW-1:0]        head;
  logic                 rdata_unused;

  function automatic logic [1:0] sat2(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  assign head         = fifo_q[rd_ptr_q];
  assign rdata_unused = pht_rdata[0];

  // Port arbitration: a full FIFO outranks fetch so updates never stall forever.
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = 2'b00;
    rd_grant  = 1'b0;
    pop       = 1'b0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = sweep_q;
        pht_wdata = INIT_VAL;
      end else if (count_q == C_QFULL) begin
        pop = 1'b1;
      end else if (rd_req) begin
        pht_en   = 1'b1;
        pht_addr = rd_index;
        rd_grant = 1'b1;
      end else if (count_q != '0) begin
        pop = 1'b1;
      end
      if (pop) begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = head[EW-1:3];
        pht_wdata = sat2(head[1:0], head[2]);
      end
    end
  end

  assign pred_taken = pht_rdata[1] & rd_grant;
  assign busy       = rst | (state_q == ST_INIT);
  assign qcount     = rst ? '0 : count_q;
  assign push       = !rst && (state_q == ST_RUN) && upd_valid && !flush_req;

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_req) begin
      state_d  = ST_INIT;
      sweep_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (state_q == ST_INIT) begin
      sweep_d = sweep_q + C_SWP_ONE;
      if (sweep_q == '1) begin
        state_d = ST_RUN;
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + C_CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {upd_index, upd_taken, upd_ctr};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_pht_sched.sv
`default_nettype none
// ============================================================================
// tb_bp_pht_sched : directed, table-driven bench for bp_pht_sched with a PHT array model
// Revision        : 1.0
// ============================================================================
module tb_bp_pht_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_req;
  logic       rd_req;
  logic [6:0] rd_index;
  logic       upd_valid;
  logic [6:0] upd_index;
  logic       upd_taken;
  logic [1:0] upd_ctr;
  logic       pht_en;
  logic       pht_we;
  logic [6:0] pht_addr;
  logic [1:0] pht_wdata;
  logic [1:0] pht_rdata;
  logic       rd_grant;
  logic       pred_taken;
  logic       busy;
  logic [2:0] qcount;

  logic [1:0] mem [128];
  logic       bad_wr = 1'b0;
  int         n_cmp  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  bp_pht_sched #(.PHT_DEPTH(7), .QDEPTH(4), .INIT_VAL(2'b01)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req),
    .rd_req(rd_req), .rd_index(rd_index),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_ctr(upd_ctr),
    .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr), .pht_wdata(pht_wdata),
    .pht_rdata(pht_rdata), .rd_grant(rd_grant), .pred_taken(pred_taken),
    .busy(busy), .qcount(qcount)
  );

  assign pht_rdata = mem[pht_addr];

  always @(posedge clk) begin
    if (pht_en === 1'b1 && pht_we === 1'b1) begin
      mem[pht_addr] <= pht_wdata;
      // Entries 7, 8, 11, 12 are only ever targeted by updates that a flush discards.
      if (pht_wdata == 2'b10 && (pht_addr == 7 || pht_addr == 8 || pht_addr == 11 || pht_addr == 12))
        bad_wr <= 1'b1;
    end
  end

  typedef struct {
    int rd, ri, uv, ui, ut, uc, fl;
    int en, we, addr, wd, gr, pr, q;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_req = 1'b0; rd_req = 1'b0; rd_index = '0;
    upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0; upd_ctr = 2'b00;
  endtask

  task automatic do_sweep(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      chk("sweep_addr", {25'd0, pht_addr}, i);
      chk("sweep_ctl", {31'd0, (pht_en === 1'b1 && pht_we === 1'b1 && pht_wdata === 2'b01 &&
                               busy === 1'b1 && rd_grant === 1'b0 && pred_taken === 1'b0 &&
                               qcount === 3'd0)}, 1);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    //        rd ri  uv ui  ut uc fl | en we addr wd gr pr q
    vecs = '{
      '{0, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0},
      '{0, 0,  1, 5,  1, 1, 0,  0, 0, 0,  0, 0, 0, 0},
      '{0, 0,  0, 0,  0, 0, 0,  1, 1, 5,  2, 0, 0, 1},
      '{1, 5,  0, 0,  0, 0, 0,  1, 0, 5,  0, 1, 1, 0},
      '{1, 3,  1, 9,  1, 3, 0,  1, 0, 3,  0, 1, 0, 0},
      '{0, 0,  1, 10, 0, 0, 0,  1, 1, 9,  3, 0, 0, 1},
      '{0, 0,  0, 0,  0, 0, 0,  1, 1, 10, 0, 0, 0, 1},
      '{0, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0},
      '{1, 20, 1, 1,  1, 1, 0,  1, 0, 20, 0, 1, 0, 0},
      '{1, 21, 1, 2,  0, 2, 0,  1, 0, 21, 0, 1, 0, 1},
      '{1, 22, 1, 3,  1, 2, 0,  1, 0, 22, 0, 1, 0, 2},
      '{1, 23, 1, 4,  0, 1, 0,  1, 0, 23, 0, 1, 0, 3},
      '{1, 24, 1, 6,  1, 3, 0,  1, 1, 1,  2, 0, 0, 4},
      '{1, 25, 0, 0,  0, 0, 0,  1, 1, 2,  1, 0, 0, 4},
      '{1, 26, 0, 0,  0, 0, 0,  1, 0, 26, 0, 1, 0, 3},
      '{0, 0,  0, 0,  0, 0, 0,  1, 1, 3,  3, 0, 0, 3},
      '{0, 0,  0, 0,  0, 0, 0,  1, 1, 4,  0, 0, 0, 2},
      '{0, 0,  0, 0,  0, 0, 0,  1, 1, 6,  3, 0, 0, 1},
      '{0, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0},
      '{1, 3,  1, 7,  1, 1, 0,  1, 0, 3,  0, 1, 1, 0},
      '{1, 4,  1, 8,  1, 1, 0,  1, 0, 4,  0, 1, 0, 1},
      '{1, 1,  1, 11, 1, 1, 0,  1, 0, 1,  0, 1, 1, 2},
      '{1, 0,  1, 12, 1, 1, 1,  1, 0, 0,  0, 1, 0, 3}
    };

    // Reset with traffic present: every output must sit at its reset value.
    idle_inputs();
    rst = 1'b1; rd_req = 1'b1; upd_valid = 1'b1; upd_index = 7'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ctl", {31'd0, (pht_en === 1'b0 && pht_we === 1'b0 && pht_addr === 7'd0 &&
                             pht_wdata === 2'b00 && rd_grant === 1'b0 && pred_taken === 1'b0)}, 1);
      chk("rst_busy", {31'd0, busy}, 1);
      chk("rst_qcount", {29'd0, qcount}, 0);
      tick();
    end

    // Power-on sweep; fetch and updates keep knocking and must be ignored.
    rst = 1'b0;
    do_sweep(0, 127);
    idle_inputs();
    @(negedge clk);
    chk("run_busy", {31'd0, busy}, 0);
    chk("run_qcount", {29'd0, qcount}, 0);
    chk("run_en", {31'd0, pht_en}, 0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== 2'b01) bad++;
    chk("init_array", bad, 0);
    tick();

    for (int k = 0; k < 23; k++) begin
      rd_req    = vecs[k].rd[0];
      rd_index  = 7'(vecs[k].ri);
      upd_valid = vecs[k].uv[0];
      upd_index = 7'(vecs[k].ui);
      upd_taken = vecs[k].ut[0];
      upd_ctr   = 2'(vecs[k].uc);
      flush_req = vecs[k].fl[0];
      @(negedge clk);
      chk($sformatf("v%0d_en", k),    {31'd0, pht_en},     vecs[k].en);
      chk($sformatf("v%0d_we", k),    {31'd0, pht_we},     vecs[k].we);
      chk($sformatf("v%0d_addr", k),  {25'd0, pht_addr},   vecs[k].addr);
      chk($sformatf("v%0d_wdata", k), {30'd0, pht_wdata},  vecs[k].wd);
      chk($sformatf("v%0d_grant", k), {31'd0, rd_grant},   vecs[k].gr);
      chk($sformatf("v%0d_pred", k),  {31'd0, pred_taken}, vecs[k].pr);
      chk($sformatf("v%0d_qcount", k), {29'd0, qcount},    vecs[k].q);
      chk($sformatf("v%0d_busy", k),  {31'd0, busy},       0);
      tick();
    end

    // After the flush in the last vector: sweep restarts, then flush again at index 60.
    idle_inputs();
    do_sweep(0, 59);
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush60_addr", {25'd0, pht_addr}, 60);
    chk("flush60_busy", {31'd0, busy}, 1);
    tick();
    flush_req = 1'b0;
    do_sweep(0, 127);
    @(negedge clk);
    chk("resweep_busy", {31'd0, busy}, 0);
    chk("resweep_qcount", {29'd0, qcount}, 0);
    chk("discarded_upd", {31'd0, bad_wr}, 0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== 2'b01) bad++;
    chk("reinit_array", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
